// File: rtl/rat_intc_if.sv
// RAT MCU port bus as seen by a peripheral: address, write data, strobe and read-back data.
interface rat_intc_if #(
  parameter int DATA_W = 8
);
  logic [7:0]        PORT_ID;
  logic [DATA_W-1:0] OUT_PORT;
  logic              IO_STRB;
  logic [DATA_W-1:0] RD_DATA;

  modport master (output PORT_ID, OUT_PORT, IO_STRB, input RD_DATA);
  modport slave  (input PORT_ID, OUT_PORT, IO_STRB, output RD_DATA);
endinterface

// File: rtl/rat_intc.sv
// Multi-source interrupt controller for the RAT MCU: synchronised, maskable, lowest-index-first
// requests to the Control_Unit, one in service at a time, ended by an EOI write.
module rat_intc #(
  parameter int               N_SRC     = 8,
  parameter int               DATA_W    = 8,
  parameter logic [7:0]       BASE_ID   = 8'hE0,
  parameter logic [N_SRC-1:0] EDGE_MODE = '1,
  parameter logic [N_SRC-1:0] MASK_RST  = '0
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic [N_SRC-1:0] IRQ,
  input  logic             INT_ACK,
  rat_intc_if.slave        bus,
  output logic             INTV,
  output logic             IN_SVC,
  output logic [2:0]       ACTIVE_ID
);

  typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

  logic [N_SRC-1:0] r_sync1, r_sync2, r_prev;
  logic [N_SRC-1:0] r_pend, r_mask;
  state_t           r_state, w_state_nxt;
  logic [2:0]       r_active, w_active_nxt;

  logic [N_SRC-1:0] w_pend, w_elig, w_set, w_w1c, w_ack_clr, w_wdata;
  logic [7:0]       w_off;
  logic             w_hit, w_wr_mask, w_wr_pend, w_wr_eoi;
  logic [2:0]       w_win;

  assign w_off     = bus.PORT_ID - BASE_ID;
  assign w_hit     = (bus.PORT_ID >= BASE_ID) && (w_off < 8'd4);
  assign w_wdata   = bus.OUT_PORT[N_SRC-1:0];
  assign w_wr_mask = bus.IO_STRB && w_hit && (w_off[1:0] == 2'd0);
  assign w_wr_pend = bus.IO_STRB && w_hit && (w_off[1:0] == 2'd1);
  assign w_wr_eoi  = bus.IO_STRB && w_hit && (w_off[1:0] == 2'd3);

  // r_prev is s2 one cycle late, so s2 & ~r_prev marks a rising edge on the synchronised line.
  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= IRQ;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Set is applied after clears so an edge arriving with a W1C or an ack is never lost.
  assign w_set = r_sync2 & ~r_prev & EDGE_MODE;
  assign w_w1c = w_wr_pend ? w_wdata : '0;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_pend <= '0;
      r_mask <= MASK_RST;
    end else begin
      r_pend <= ((r_pend & ~w_w1c & ~w_ack_clr) | w_set) & EDGE_MODE;
      if (w_wr_mask) r_mask <= w_wdata;
    end
  end

  assign w_pend = (r_pend & EDGE_MODE) | (r_sync2 & ~EDGE_MODE);
  assign w_elig = w_pend & r_mask;

  // Scanning downwards leaves the lowest set index as the winner.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_win = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) w_win = 3'(i);
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_state  <= IDLE;
      r_active <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_active <= w_active_nxt;
    end
  end

  // An ack is honoured even if eligibility vanished this cycle: INTV was already seen by the CU.
  always_comb begin
    w_state_nxt  = r_state;
    w_active_nxt = r_active;
    w_ack_clr    = '0;
    unique case (r_state)
      IDLE: begin
        if (|w_elig) begin
          w_state_nxt  = REQ;
          w_active_nxt = w_win;
        end
      end
      REQ: begin
        if (INT_ACK) begin
          w_state_nxt = SVC;
          for (int i = 0; i < N_SRC; i++) w_ack_clr[i] = (r_active == 3'(i));
        end else if (!(|w_elig)) begin
          w_state_nxt = IDLE;
        end else begin
          w_active_nxt = w_win;
        end
      end
      SVC: begin
        if (w_wr_eoi) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign INTV      = (r_state == REQ);
  assign IN_SVC    = (r_state == SVC);
  assign ACTIVE_ID = r_active;

  always_comb begin
    bus.RD_DATA = '0;
    if (w_hit) begin
      unique case (w_off[1:0])
        2'd0:    bus.RD_DATA[N_SRC-1:0] = r_mask;
        2'd1:    bus.RD_DATA[N_SRC-1:0] = w_pend;
        2'd2:    bus.RD_DATA[7:0]       = {IN_SVC, INTV, 3'b000, r_active};
        default: bus.RD_DATA            = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_rat_intc.sv
// Scoreboard bench for rat_intc: directed scenarios then random traffic, every cycle compared
// against a sample-history reference model of the controller.
module tb_rat_intc;

  localparam logic [7:0] BASE   = 8'hE0;
  localparam logic [7:0] A_MASK = 8'hE0;
  localparam logic [7:0] A_PEND = 8'hE1;
  localparam logic [7:0] A_STAT = 8'hE2;
  localparam logic [7:0] A_EOI  = 8'hE3;
  localparam logic [7:0] EDGE   = 8'hFE;
  localparam logic [7:0] MRST   = 8'h00;

  logic       clk = 1'b0;
  logic       d_rst = 1'b1;
  logic [7:0] d_irq = '0;
  logic [7:0] d_pid = A_STAT;
  logic [7:0] d_dout = '0;
  logic       d_strb = 1'b0;
  logic       d_ack = 1'b0;
  logic       intv, in_svc;
  logic [2:0] active_id;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rat_intc_if #(.DATA_W(8)) bus ();
  assign bus.PORT_ID  = d_pid;
  assign bus.OUT_PORT = d_dout;
  assign bus.IO_STRB  = d_strb;

  rat_intc #(
    .N_SRC(8), .DATA_W(8), .BASE_ID(BASE), .EDGE_MODE(EDGE), .MASK_RST(MRST)
  ) dut (
    .clk(clk), .RESET(d_rst), .IRQ(d_irq), .INT_ACK(d_ack), .bus(bus),
    .INTV(intv), .IN_SVC(in_svc), .ACTIVE_ID(active_id)
  );

  // Reference model: pending sources, mask, and which interrupt is offered or being served.
  typedef enum {M_IDLE, M_REQ, M_SVC} mode_t;
  typedef struct {
    logic       intv;
    logic       svc;
    logic [2:0] act;
    logic [7:0] rd;
  } exp_t;

  mode_t      m_mode;
  logic [7:0] m_mask, m_pend;
  logic [2:0] m_act;
  logic [7:0] hist[$];  // IRQ as sampled on recent edges, newest first
  exp_t       sb_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_mask = MRST;
    m_pend = '0;
    m_act  = '0;
    hist   = {8'h00, 8'h00, 8'h00};
  endtask

  // Synchronised level is the sample from two edges back; a rise is that vs the one before it.
  function automatic logic [7:0] pend_view();
    return (m_pend & EDGE) | (hist[1] & ~EDGE);
  endfunction

  task automatic model_edge();
    logic [7:0] elig, rise, clr, w1c;
    if (d_rst) begin
      model_reset();
      return;
    end
    elig = pend_view() & m_mask;
    rise = hist[1] & ~hist[2] & EDGE;
    clr  = '0;
    w1c  = (d_strb && d_pid == A_PEND) ? d_dout : 8'h00;
    case (m_mode)
      M_IDLE: if (elig != 0) begin m_mode = M_REQ; m_act = lowest(elig); end
      M_REQ: begin
        if (d_ack) begin
          m_mode = M_SVC;
          clr = (8'h01 << m_act) & EDGE;
        end else if (elig == 0) m_mode = M_IDLE;
        else m_act = lowest(elig);
      end
      M_SVC: if (d_strb && d_pid == A_EOI) m_mode = M_IDLE;
      default: m_mode = M_IDLE;
    endcase
    m_pend = ((m_pend & ~clr & ~w1c) | rise) & EDGE;
    if (d_strb && d_pid == A_MASK) m_mask = d_dout;
    hist.push_front(d_irq);
    void'(hist.pop_back());
  endtask

  function automatic exp_t expect_now();
    exp_t e;
    e.intv = (m_mode == M_REQ);
    e.svc  = (m_mode == M_SVC);
    e.act  = m_act;
    case (d_pid)
      A_MASK:  e.rd = m_mask;
      A_PEND:  e.rd = pend_view();
      A_STAT:  e.rd = {e.svc, e.intv, 3'b000, m_act};
      default: e.rd = 8'h00;
    endcase
    return e;
  endfunction

  // One cycle: advance the model on the edge, then drive the inputs for the following cycle.
  task automatic step(input logic [7:0] irq, input logic [7:0] pid, input logic [7:0] dout,
                      input logic strb, input logic ack);
    @(posedge clk);
    model_edge();
    #1;
    d_irq = irq; d_pid = pid; d_dout = dout; d_strb = strb; d_ack = ack;
    sb_q.push_back(expect_now());
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("intv",      32'(intv),        32'(e.intv));
      check("in_svc",    32'(in_svc),      32'(e.svc));
      check("active_id", 32'(active_id),   32'(e.act));
      check("rd_data",   32'(bus.RD_DATA), 32'(e.rd));
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] r_irq;
    logic [7:0] pid;
    model_reset();
    repeat (3) step(8'h00, A_STAT, 8'h00, 1'b0, 1'b0);
    d_rst = 1'b0;
    step(8'h00, A_STAT, 8'h00, 1'b0, 1'b0);
    at_neg(); check("reset_status", 32'(bus.RD_DATA), 32'h00);
    step(8'h00, A_MASK, 8'h00, 1'b0, 1'b0);
    at_neg(); check("reset_mask", 32'(bus.RD_DATA), 32'(MRST));

    // Masked pulse on source 3 is latched but not requested until unmasked.
    step(8'h08, A_PEND, 8'h00, 1'b0, 1'b0);
    repeat (4) step(8'h00, A_PEND, 8'h00, 1'b0, 1'b0);
    at_neg(); check("t1_pend", 32'(bus.RD_DATA), 32'h08);
    check("t1_intv_masked", 32'(intv), 32'h0);
    step(8'h00, A_MASK, 8'h08, 1'b1, 1'b0);
    step(8'h00, A_STAT, 8'h00, 1'b0, 1'b0);
    at_neg(); check("t1_intv_write_edge", 32'(intv), 32'h0);
    step(8'h00, A_STAT, 8'h00, 1'b0, 1'b0);
    at_neg(); check("t1_status", 32'(bus.RD_DATA), 32'h43);
    step(8'h00, A_STAT, 8'h00, 1'b0, 1'b1);
    step(8'h00, A_EOI, 8'h00, 1'b1, 1'b0);
    step(8'h00, A_STAT, 8'h00, 1'b0, 1'b0);

    // Sources 5 and 2 together: 2 wins, 5 follows after EOI.
    step(8'h00, A_MASK, 8'hFF, 1'b1, 1'b0);
    repeat (5) step(8'h24, A_STAT, 8'h00, 1'b0, 1'b0);
    at_neg(); check("t2_status", 32'(bus.RD_DATA), 32'h42);
    step(8'h24, A_PEND, 8'h00, 1'b0, 1'b1);
    step(8'h24, A_PEND, 8'h00, 1'b0, 1'b0);
    at_neg(); check("t2_pend_after_ack", 32'(bus.RD_DATA), 32'h20);
    check("t2_in_svc", 32'(in_svc), 32'h1);
    check("t2_intv_svc", 32'(intv), 32'h0);
    step(8'h24, A_EOI, 8'h00, 1'b1, 1'b0);
    step(8'h24, A_STAT, 8'h00, 1'b0, 1'b0);
    step(8'h24, A_STAT, 8'h00, 1'b0, 1'b0);
    at_neg(); check("t2_next_grant", 32'(bus.RD_DATA), 32'h45);

    // Source 1 arrives while 5 is requested and overrides it before the ack.
    repeat (5) step(8'h26, A_STAT, 8'h00, 1'b0, 1'b0);
    at_neg(); check("t3_override", 32'(bus.RD_DATA), 32'h41);
    step(8'h26, A_STAT, 8'h00, 1'b0, 1'b1);
    step(8'h26, A_STAT, 8'h00, 1'b0, 1'b0);
    at_neg(); check("t3_svc_src1", 32'(bus.RD_DATA), 32'h81);
    step(8'h26, A_EOI, 8'h00, 1'b1, 1'b0);
    repeat (2) step(8'h26, A_STAT, 8'h00, 1'b0, 1'b0);

    // Level source 0 ignores W1C and ack, and follows the line.
    step(8'h00, A_PEND, 8'h20, 1'b1, 1'b0);
    repeat (2) step(8'h00, A_PEND, 8'h00, 1'b0, 1'b0);
    step(8'h01, A_PEND, 8'h00, 1'b0, 1'b0);
    repeat (3) step(8'h01, A_PEND, 8'h00, 1'b0, 1'b0);
    at_neg(); check("t4_level_pend", 32'(bus.RD_DATA), 32'h01);
    check("t4_intv", 32'(intv), 32'h1);
    step(8'h01, A_PEND, 8'h01, 1'b1, 1'b0);
    step(8'h01, A_PEND, 8'h00, 1'b0, 1'b0);
    at_neg(); check("t4_w1c_ignored", 32'(bus.RD_DATA), 32'h01);
    step(8'h01, A_STAT, 8'h00, 1'b0, 1'b1);
    step(8'h01, A_STAT, 8'h00, 1'b0, 1'b0);
    at_neg(); check("t4_svc_src0", 32'(bus.RD_DATA), 32'h80);
    step(8'h01, A_EOI, 8'h00, 1'b1, 1'b0);
    repeat (2) step(8'h01, A_STAT, 8'h00, 1'b0, 1'b0);
    at_neg(); check("t4_reassert", 32'(bus.RD_DATA), 32'h40);
    step(8'h00, A_PEND, 8'h00, 1'b0, 1'b0);
    step(8'h00, A_PEND, 8'h00, 1'b0, 1'b0);
    at_neg(); check("t4_level_hold", 32'(bus.RD_DATA), 32'h01);
    step(8'h00, A_PEND, 8'h00, 1'b0, 1'b0);
    at_neg(); check("t4_level_clear", 32'(bus.RD_DATA), 32'h00);

    // Edge set on source 4 lands on the same edge as a W1C of bit 4.
    repeat (2) step(8'h10, A_STAT, 8'h00, 1'b0, 1'b0);
    step(8'h10, A_PEND, 8'h10, 1'b1, 1'b0);
    step(8'h10, A_PEND, 8'h00, 1'b0, 1'b0);
    at_neg(); check("t5_set_wins", 32'(bus.RD_DATA), 32'h10);
    step(8'h10, A_STAT, 8'h00, 1'b0, 1'b0);
    at_neg(); check("t5_grant4", 32'(bus.RD_DATA), 32'h44);

    // Async reset in the middle of a service, with source 6 pending.
    step(8'h10, A_STAT, 8'h00, 1'b0, 1'b1);
    repeat (4) step(8'h50, A_PEND, 8'h00, 1'b0, 1'b0);
    at_neg(); check("t6_pend_before", 32'(bus.RD_DATA), 32'h40);
    check("t6_in_svc_before", 32'(in_svc), 32'h1);
    d_rst = 1'b1;
    model_reset();
    #1;
    check("t6_in_svc_rst", 32'(in_svc), 32'h0);
    check("t6_intv_rst", 32'(intv), 32'h0);
    check("t6_pend_rst", 32'(bus.RD_DATA), 32'h00);
    d_pid = A_MASK;
    #1;
    check("t6_mask_rst", 32'(bus.RD_DATA), 32'(MRST));
    repeat (2) step(8'h50, A_STAT, 8'h00, 1'b0, 1'b0);
    d_rst = 1'b0;
    step(8'h50, A_STAT, 8'h00, 1'b0, 1'b1);
    step(8'h50, A_STAT, 8'h00, 1'b0, 1'b0);
    at_neg(); check("t6_ack_ignored", 32'(bus.RD_DATA), 32'h00);

    // Random traffic: sparse IRQ toggles, register accesses, stray acks.
    step(8'h50, A_MASK, 8'hFF, 1'b1, 1'b0);
    r_irq = 8'h50;
    for (int n = 0; n < 800; n++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 7) == 0) r_irq[b] = ~r_irq[b];
      if ($urandom_range(0, 7) == 0) pid = 8'($urandom);
      else pid = BASE + 8'($urandom_range(0, 3));
      step(r_irq, pid, 8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
    end

    at_neg();
    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
